// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: widths, round count, rcon constants,
// schedule state enum and the GF(2^8) xtime helper.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int WORD_W  = 32;
    localparam int ROUND_W = 4;
    localparam int NR      = 10;

    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out handshake bundle between the key source, the
// round datapath and the key schedule.
interface aes_key_expand_if;
    import aes_pkg::*;

    logic                 key_valid;
    logic                 key_ready;
    logic [STATE_W-1:0]   key_in;
    logic                 rk_valid;
    logic                 rk_ready;
    logic [STATE_W-1:0]   rk_out;
    logic [ROUND_W-1:0]   rk_round;
    logic                 flush;

    modport master (
        output key_valid, key_in, rk_ready, flush,
        input  key_ready, rk_valid, rk_out, rk_round
    );

    modport slave (
        input  key_valid, key_in, rk_ready, flush,
        output key_ready, rk_valid, rk_out, rk_round
    );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte, pure lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes_sub_word.sv
// SubWord: S-box applied independently to each byte of a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word
);

    for (genvar i = 0; i < WORD_W / 8; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (i_word[8*i +: 8]),
            .o_byte (o_word[8*i +: 8])
        );
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: stores only the current round key and
// derives the next one combinationally. Optional macro: AES_KEY_EXPAND_LAST_KEY_EN.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    aes_key_expand_if.slave    bus
`ifdef AES_KEY_EXPAND_LAST_KEY_EN
    ,
    output logic [STATE_W-1:0] last_key,
    output logic               last_key_valid
`endif
);

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NR);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [STATE_W-1:0]   r_rk;
    logic [ROUND_W-1:0]   r_round;
    logic [7:0]           r_rcon;

    logic                 w_take_key;
    logic                 w_take_rk;
    logic [WORD_W-1:0]    w_rot;
    logic [WORD_W-1:0]    w_sub;
    logic [WORD_W-1:0]    w_t;
    logic [WORD_W-1:0]    w_n0, w_n1, w_n2, w_n3;
    logic [STATE_W-1:0]   w_next_rk;

    // RotWord: byte 0 of w3 moves to byte 3.
    assign w_rot = {r_rk[103:96], r_rk[127:104]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    assign w_t       = w_sub ^ {24'h0, r_rcon};
    assign w_n0      = r_rk[31:0]   ^ w_t;
    assign w_n1      = r_rk[63:32]  ^ w_n0;
    assign w_n2      = r_rk[95:64]  ^ w_n1;
    assign w_n3      = r_rk[127:96] ^ w_n2;
    assign w_next_rk = {w_n3, w_n2, w_n1, w_n0};

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // flush outranks both handshakes, so neither is taken while it is high.
    always_comb begin
        w_state_nxt = r_state;
        w_take_key  = 1'b0;
        w_take_rk   = 1'b0;
        if (bus.flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_take_key = bus.key_valid;
                    if (bus.key_valid) w_state_nxt = EMIT;
                end
                EMIT: begin
                    w_take_rk = bus.rk_ready;
                    if (bus.rk_ready && r_round == LAST_RND) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rk    <= '0;
            r_round <= '0;
            r_rcon  <= RCON_INIT;
        end else if (w_take_key) begin
            r_rk    <= bus.key_in;
            r_round <= '0;
            r_rcon  <= RCON_INIT;
        end else if (w_take_rk && r_round != LAST_RND) begin
            r_rk    <= w_next_rk;
            r_round <= r_round + 1'b1;
            r_rcon  <= xtime(r_rcon);
        end
    end

`ifdef AES_KEY_EXPAND_LAST_KEY_EN
    logic [STATE_W-1:0] r_last_key;
    logic               r_last_key_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || w_take_key) begin
            r_last_key       <= '0;
            r_last_key_valid <= 1'b0;
        end else if (w_take_rk && r_round == LAST_RND) begin
            r_last_key       <= r_rk;
            r_last_key_valid <= 1'b1;
        end
    end

    assign last_key       = r_last_key;
    assign last_key_valid = r_last_key_valid;
`endif

    assign bus.key_ready = (r_state == IDLE) && rst_n;
    assign bus.rk_valid  = (r_state == EMIT);
    assign bus.rk_out    = r_rk;
    assign bus.rk_round  = r_round;

endmodule
